// File: rtl/one_two_demux_reg_pkg.sv
// ----------------------------------------------------------------------------
// one_two_demux_reg_pkg
// Shared definitions for the one-to-two registered demultiplexer.
//   state_t      : FSM encoding (IDLE = 00, HOLD0 = 01, HOLD1 = 10)
//   DEFAULT_SIZE : default data width in bits
//   CNT_WIDTH    : width of the optional per-destination transfer counters
// ----------------------------------------------------------------------------
package one_two_demux_reg_pkg;

    // IDLE means the holding register is empty. HOLDk means it holds a word
    // that is being offered to destination k.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD0 = 2'b01,
        HOLD1 = 2'b10
    } state_t;

    localparam int DEFAULT_SIZE = 16;
    localparam int CNT_WIDTH    = 16;

endpackage

// File: rtl/one_two_demux_reg_xfer_counter.sv
// ----------------------------------------------------------------------------
// xfer_counter
// Free-running transfer counter that wraps from all-ones back to zero.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears the count
//   en    : count one transfer this cycle
//   count : current count
// ----------------------------------------------------------------------------
module xfer_counter
    import one_two_demux_reg_pkg::*;
#(
    parameter int width = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [width-1:0] count
);

    // Count one per enabled cycle. Overflow simply wraps, which is the
    // intended behaviour for a statistics counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/one_two_demux_reg.sv
// ----------------------------------------------------------------------------
// one_two_demux_reg
// Routes each accepted input word to one of two destinations through a single
// holding register. Valid/ready handshakes on all sides. A word accepted on
// one cycle is offered on the selected output on the next cycle, and a new
// word can be accepted in the same cycle the held one leaves, so the block
// sustains one word per cycle.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   in_data/in_sel        : source word and destination select (0=out0, 1=out1)
//   in_valid/in_ready     : source handshake (in_ready is combinational)
//   outk_data/outk_valid  : destination k word and valid (data is zero
//                           whenever destination k is not being offered)
//   outk_ready            : destination k accepts
//   cnt0/cnt1             : per-destination transfer counts, present only
//                           when ONE_TWO_DEMUX_STATS_EN is defined
// Build option: ONE_TWO_DEMUX_STATS_EN adds the transfer counters.
// ----------------------------------------------------------------------------
module one_two_demux_reg
    import one_two_demux_reg_pkg::*;
#(
    parameter int size = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] in_data,
    input  logic            in_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [size-1:0] out0_data,
    output logic            out0_valid,
    input  logic            out0_ready,
    output logic [size-1:0] out1_data,
    output logic            out1_valid,
    input  logic            out1_ready
`ifdef ONE_TWO_DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    state_t          state_q;
    state_t          state_d;
    logic [size-1:0] hold_q;

    // Next-state and handshake decode. The input may only be accepted when
    // the holding register is empty or is being drained this very cycle,
    // which is why in_ready follows the active destination's ready while a
    // word is held. An input transfer always wins the next state so that a
    // back-to-back word replaces the departing one without a bubble.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            HOLD0: begin
                in_ready   = out0_ready;
                out0_valid = 1'b1;
                if (out0_ready) begin
                    state_d = IDLE;
                end
            end
            HOLD1: begin
                in_ready   = out1_ready;
                out1_valid = 1'b1;
                if (out1_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (in_valid && in_ready) begin
            state_d = in_sel ? HOLD1 : HOLD0;
        end
    end

    // State and holding register. in_data is only captured on an accepted
    // transfer, so it is free to change at any other time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (in_valid && in_ready) begin
                hold_q <= in_data;
            end
        end
    end

    // The idle output is forced to zero so a destination never sees a stale
    // word that was meant for the other side.
    assign out0_data = out0_valid ? hold_q : '0;
    assign out1_data = out1_valid ? hold_q : '0;

`ifdef ONE_TWO_DEMUX_STATS_EN
    logic out0_fire;
    logic out1_fire;

    assign out0_fire = out0_valid & out0_ready;
    assign out1_fire = out1_valid & out1_ready;

    xfer_counter #(.width(CNT_WIDTH)) u_cnt0 (
        .clk   (clk),
        .reset (reset),
        .en    (out0_fire),
        .count (cnt0)
    );

    xfer_counter #(.width(CNT_WIDTH)) u_cnt1 (
        .clk   (clk),
        .reset (reset),
        .en    (out1_fire),
        .count (cnt1)
    );
`endif

endmodule

// File: tb/tb_one_two_demux_reg.sv
// ----------------------------------------------------------------------------
// tb_one_two_demux_reg
// Directed bench for one_two_demux_reg. The stimulus process pushes the
// expected (destination, word) for every word it expects the DUT to accept;
// a monitor pops and compares on each output handshake. Direct checks cover
// reset state, latency, stalls and counter values.
// ----------------------------------------------------------------------------
module tb_one_two_demux_reg;

    typedef struct packed {
        logic        dest;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
`ifdef ONE_TWO_DEMUX_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    one_two_demux_reg #(.size(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef ONE_TWO_DEMUX_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a broken DUT can never hang the run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog time limit expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic sel, input logic [15:0] data,
                                 input logic r0, input logic r1);
        in_valid   = valid;
        in_sel     = sel;
        in_data    = data;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic expectWord(input logic dest, input logic [15:0] data);
        exp_t e;
        e.dest = dest;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: sample away from the active edge and compare every
    // output handshake with the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out0_valid || out1_valid) begin
                    checkOutput("valid_exclusive", {30'd0, out0_valid, out1_valid}, {30'd0, out0_valid, !out0_valid});
                end
                if (out0_valid && out0_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL sb_unexpected out0 actual=%0h expected=none", out0_data);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("sb_dest0", 32'(1'b0), 32'(e.dest));
                        checkOutput("sb_data0", 32'(out0_data), 32'(e.data));
                    end
                end
                if (out1_valid && out1_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL sb_unexpected out1 actual=%0h expected=none", out1_data);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("sb_dest1", 32'(1'b1), 32'(e.dest));
                        checkOutput("sb_data1", 32'(out1_data), 32'(e.data));
                    end
                end
            end
        end
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_out0_valid"}, 32'(out0_valid), 32'd0);
        checkOutput({tag, "_out1_valid"}, 32'(out1_valid), 32'd0);
        checkOutput({tag, "_out0_data"}, 32'(out0_data), 32'd0);
        checkOutput({tag, "_out1_data"}, 32'(out1_data), 32'd0);
    endtask

    task automatic pulseReset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;

        // Reset then idle.
        mid();
        checkIdle("reset");
`ifdef ONE_TWO_DEMUX_STATS_EN
        checkOutput("reset_cnt0", 32'(cnt0), 32'd0);
        checkOutput("reset_cnt1", 32'(cnt1), 32'd0);
`endif

        // Single word to out0, one-cycle latency.
        applyStimulus(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        expectWord(1'b0, 16'h1234);
        step();
        in_valid = 1'b0;
        mid();
        checkOutput("t1_out0_valid", 32'(out0_valid), 32'd1);
        checkOutput("t1_out0_data", 32'(out0_data), 32'h1234);
        checkOutput("t1_out1_valid", 32'(out1_valid), 32'd0);
        checkOutput("t1_out1_data", 32'(out1_data), 32'd0);
        step();
        mid();
        checkIdle("t1_after");
`ifdef ONE_TWO_DEMUX_STATS_EN
        checkOutput("t1_cnt0", 32'(cnt0), 32'd1);
`endif

        // Stall on out1 for three cycles while a second word is offered.
        applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
        expectWord(1'b1, 16'hBEEF);
        step();
        applyStimulus(1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mid();
            checkOutput("t2_stall_out1_valid", 32'(out1_valid), 32'd1);
            checkOutput("t2_stall_out1_data", 32'(out1_data), 32'hBEEF);
            checkOutput("t2_stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("t2_stall_out0_valid", 32'(out0_valid), 32'd0);
            step();
        end
        applyStimulus(1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1);
        mid();
        checkOutput("t2_release_out1_data", 32'(out1_data), 32'hBEEF);
        step();
        mid();
        checkIdle("t2_after");
`ifdef ONE_TWO_DEMUX_STATS_EN
        checkOutput("t2_cnt0", 32'(cnt0), 32'd1);
        checkOutput("t2_cnt1", 32'(cnt1), 32'd1);
`endif

        // Back-to-back stream with alternating destinations.
        pulseReset();
        applyStimulus(1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);
        expectWord(1'b0, 16'h0001);
        step();
        applyStimulus(1'b1, 1'b1, 16'h0002, 1'b1, 1'b1);
        expectWord(1'b1, 16'h0002);
        mid();
        checkOutput("t3_w1_out0_data", 32'(out0_data), 32'h0001);
        checkOutput("t3_w1_in_ready", 32'(in_ready), 32'd1);
        step();
        applyStimulus(1'b1, 1'b0, 16'h0003, 1'b1, 1'b1);
        expectWord(1'b0, 16'h0003);
        mid();
        checkOutput("t3_w2_out1_valid", 32'(out1_valid), 32'd1);
        checkOutput("t3_w2_out1_data", 32'(out1_data), 32'h0002);
        checkOutput("t3_w2_out0_data", 32'(out0_data), 32'd0);
        step();
        in_valid = 1'b0;
        mid();
        checkOutput("t3_w3_out0_data", 32'(out0_data), 32'h0003);
        step();
        mid();
        checkIdle("t3_after");
`ifdef ONE_TWO_DEMUX_STATS_EN
        checkOutput("t3_cnt0", 32'(cnt0), 32'd2);
        checkOutput("t3_cnt1", 32'(cnt1), 32'd1);
`endif

        // Reset while HOLD1 holds a word that out1 is not taking.
        applyStimulus(1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        mid();
        checkOutput("t4_hold_out1_data", 32'(out1_data), 32'h5A5A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        out1_ready = 1'b1;
        mid();
        checkIdle("t4_reset");
`ifdef ONE_TWO_DEMUX_STATS_EN
        checkOutput("t4_cnt1", 32'(cnt1), 32'd0);
`endif
        in_sel  = 1'b1;
        in_data = 16'hFFFF;
        step();
        mid();
        checkOutput("t4_no_replay_out1_valid", 32'(out1_valid), 32'd0);

`ifdef ONE_TWO_DEMUX_STATS_EN
        // Wrap cnt0 with 65536 back-to-back transfers.
        pulseReset();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            in_data = 16'(i);
            expectWord(1'b0, 16'(i));
            step();
        end
        in_valid = 1'b0;
        mid();
        checkOutput("t5_cnt0_pre_wrap", 32'(cnt0), 32'hFFFF);
        step();
        mid();
        checkOutput("t5_cnt0_wrap", 32'(cnt0), 32'd0);
        checkOutput("t5_cnt1", 32'(cnt1), 32'd0);
        checkOutput("t5_out0_valid", 32'(out0_valid), 32'd0);
`endif

        step();
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
